// File: rtl/intpol2_out_packer_if.sv
// Handshake bundle around the interpolator output packer: sample strobe and
// back-pressure on the core side, valid/ready packed-word stream on the host side.
interface intpol2_out_packer_if #(
  parameter int DATAPATH_WIDTH = 12
);
  logic                      Write_enable_i;
  logic [DATAPATH_WIDTH-1:0] I_interp_i;
  logic [DATAPATH_WIDTH-1:0] Q_interp_i;
  logic                      Afull_o;
  logic [31:0]               m_data_o;
  logic                      m_valid_o;
  logic                      m_ready_i;

  // Packer side.
  modport slave (
    input  Write_enable_i, I_interp_i, Q_interp_i, m_ready_i,
    output Afull_o, m_data_o, m_valid_o
  );

  // Core and consumer side.
  modport master (
    output Write_enable_i, I_interp_i, Q_interp_i, m_ready_i,
    input  Afull_o, m_data_o, m_valid_o
  );
endinterface

// File: rtl/intpol2_out_packer.sv
// Interpolator output FIFO: packs I/Q pairs into 32-bit words and streams them out.
// Define INTPOL2_OUT_OVFCNT_EN to add the saturating dropped-sample counter ovf_cnt_o.
module intpol2_out_packer #(
  parameter int DATAPATH_WIDTH = 12,
  parameter int ADDR_WIDTH     = 3,
  parameter int AF_MARGIN      = 2
) (
  input  logic                  clk,
  input  logic                  rst_a,
  intpol2_out_packer_if.slave   bus,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  ovf_o,
  input  logic                  clr_ovf_i
`ifdef INTPOL2_OUT_OVFCNT_EN
  ,
  output logic [15:0]           ovf_cnt_o
`endif
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, drop;
  logic [31:0]           wdata;

  assign wdata = {16'(signed'(bus.Q_interp_i)), 16'(signed'(bus.I_interp_i))};

  always_comb begin
    pop  = (count_q != '0) && (!valid_q || bus.m_ready_i);
    // At full, a same-cycle pop frees the slot the write lands in.
    push = bus.Write_enable_i && ((count_q != FULL_LVL) || pop);
    drop = bus.Write_enable_i && (count_q == FULL_LVL) && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    data_d  = pop ? mem_q[rd_ptr_q] : data_q;
    valid_d = valid_q;
    if (pop)                            valid_d = 1'b1;
    else if (valid_q && bus.m_ready_i)  valid_d = 1'b0;

    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push && !rst_a) mem_q[wr_ptr_q] <= wdata;
  end

`ifdef INTPOL2_OUT_OVFCNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_ovf_i)                      ovf_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && ovf_cnt_q != '1)   ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_a) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

  assign bus.Afull_o   = (count_q >= AF_LVL);
  assign bus.m_data_o  = data_q;
  assign bus.m_valid_o = valid_q;
  assign level_o       = count_q;
  assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_intpol2_out_packer.sv
// Directed bench for intpol2_out_packer: scoreboard of packed words, latency,
// fill/almost-full, overflow, push+pop at full, random back-pressure, mid-stream reset.
module tb_intpol2_out_packer;
  localparam int DW = 12;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_a;
  logic clr_ovf_i;
  logic [AW:0] level_o;
  logic ovf_o;
`ifdef INTPOL2_OUT_OVFCNT_EN
  logic [15:0] ovf_cnt_o;
`endif

  intpol2_out_packer_if #(.DATAPATH_WIDTH(DW)) bus ();

  intpol2_out_packer #(.DATAPATH_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(2)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .bus       (bus),
    .level_o   (level_o),
    .ovf_o     (ovf_o),
    .clr_ovf_i (clr_ovf_i)
`ifdef INTPOL2_OUT_OVFCNT_EN
    ,
    .ovf_cnt_o (ovf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pack(logic [DW-1:0] i, logic [DW-1:0] q);
    return {{(16-DW){q[DW-1]}}, q, {(16-DW){i[DW-1]}}, i};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one strobe; an accepted sample is queued as the expected output.
  task automatic push_word(logic [DW-1:0] i, logic [DW-1:0] q, bit accept);
    bus.Write_enable_i = 1'b1;
    bus.I_interp_i     = i;
    bus.Q_interp_i     = q;
    if (accept) exp_q.push_back(pack(i, q));
    @(posedge clk); #1;
    bus.Write_enable_i = 1'b0;
  endtask

  task automatic drain(string tag);
    bus.m_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && bus.m_valid_o === 1'b0) break;
      @(posedge clk); #1;
    end
    chk(tag, {31'd0, (exp_q.size() == 0 && bus.m_valid_o === 1'b0)}, 32'd1);
  endtask

  // Strobe with an empty pipeline and ready high: valid exactly one cycle,
  // appearing after the second edge.
  task automatic latency(string tag, logic [DW-1:0] i, logic [DW-1:0] q);
    bus.m_ready_i = 1'b1;
    push_word(i, q, 1'b1);
    @(negedge clk); chk({tag, "_v0"}, {31'd0, bus.m_valid_o}, 32'd0);
    @(negedge clk); chk({tag, "_v1"}, {31'd0, bus.m_valid_o}, 32'd1);
    chk({tag, "_data"}, bus.m_data_o, pack(i, q));
    @(negedge clk); chk({tag, "_v2"}, {31'd0, bus.m_valid_o}, 32'd0);
  endtask

  // Output monitor: scoreboard pop on every transfer, stability while stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_a !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.m_valid_o}, 32'd1);
        chk("stall_data", bus.m_data_o, prev_data);
      end
      if (bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_word", bus.m_data_o, 32'hxxxx_xxxx);
        else                   chk("sb_word", bus.m_data_o, exp_q.pop_front());
      end
      prev_stall = (bus.m_valid_o === 1'b1) && (bus.m_ready_i === 1'b0);
      prev_data  = bus.m_data_o;
    end
  end

  initial begin
    int idx;
    rst_a = 1'b1; clr_ovf_i = 1'b0;
    bus.Write_enable_i = 1'b0; bus.I_interp_i = '0; bus.Q_interp_i = '0;
    bus.m_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
    chk("rst_data", bus.m_data_o, 32'd0);
    chk("rst_afull", {31'd0, bus.Afull_o}, 32'd0);
    chk("rst_level", {28'd0, level_o}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
`ifdef INTPOL2_OUT_OVFCNT_EN
    chk("rst_ovfcnt", {16'd0, ovf_cnt_o}, 32'd0);
`endif

    // Single sample, extreme codes
    @(posedge clk); #1;
    latency("single", 12'h7FF, 12'h800);
    chk("single_word_val", pack(12'h7FF, 12'h800), 32'hF800_07FF);

    // Fill and almost-full
    @(posedge clk); #1;
    bus.m_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) push_word(12'(12'h100 + k), 12'(12'hA00 + k), 1'b1);
    chk("fill6_level", {28'd0, level_o}, 32'd5);
    chk("fill6_afull", {31'd0, bus.Afull_o}, 32'd0);
    push_word(12'h106, 12'hA06, 1'b1);
    chk("fill7_level", {28'd0, level_o}, 32'd6);
    chk("fill7_afull", {31'd0, bus.Afull_o}, 32'd1);
    chk("fill7_valid", {31'd0, bus.m_valid_o}, 32'd1);
    push_word(12'h107, 12'hA07, 1'b1);
    push_word(12'h108, 12'hA08, 1'b1);
    chk("full_level", {28'd0, level_o}, 32'd8);
    chk("full_ovf", {31'd0, ovf_o}, 32'd0);

    // Overflow: three drops while stalled
    for (int k = 0; k < 3; k++) push_word(12'(12'h3F0 + k), 12'h3F0, 1'b0);
    chk("ovf_flag", {31'd0, ovf_o}, 32'd1);
    chk("ovf_level", {28'd0, level_o}, 32'd8);
`ifdef INTPOL2_OUT_OVFCNT_EN
    chk("ovf_cnt", {16'd0, ovf_cnt_o}, 32'd3);
`endif
    drain("ovf_drain");
    chk("ovf_sticky", {31'd0, ovf_o}, 32'd1);
    clr_ovf_i = 1'b1;
    @(posedge clk); #1;
    clr_ovf_i = 1'b0;
    chk("ovf_clr", {31'd0, ovf_o}, 32'd0);
`ifdef INTPOL2_OUT_OVFCNT_EN
    chk("ovf_cnt_clr", {16'd0, ovf_cnt_o}, 32'd0);
`endif

    // Push and pop at full
    bus.m_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) push_word(12'(12'h200 + k), 12'(12'hC00 + k), 1'b1);
    chk("pp_full_level", {28'd0, level_o}, 32'd8);
    bus.m_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) push_word(12'(12'h300 + k), 12'(12'hD00 + k), 1'b1);
    chk("pp_level", {28'd0, level_o}, 32'd8);
    chk("pp_no_ovf", {31'd0, ovf_o}, 32'd0);
    drain("pp_drain");

    // Random back-pressure against a ramp, strobes gated by almost-full
    idx = 0;
    for (int c = 0; c < 3000; c++) begin
      if (idx == 100 && exp_q.size() == 0 && bus.m_valid_o === 1'b0) break;
      bus.m_ready_i = 1'($urandom_range(0, 1));
      if (idx < 100 && bus.Afull_o === 1'b0) begin
        bus.Write_enable_i = 1'b1;
        bus.I_interp_i = 12'(idx);
        bus.Q_interp_i = 12'(12'hFFF - idx);
        exp_q.push_back(pack(12'(idx), 12'(12'hFFF - idx)));
        idx++;
      end else begin
        bus.Write_enable_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.Write_enable_i = 1'b0;
    chk("ramp_all_sent", idx, 32'd100);
    chk("ramp_done", {31'd0, (exp_q.size() == 0 && bus.m_valid_o === 1'b0)}, 32'd1);
    chk("ramp_no_ovf", {31'd0, ovf_o}, 32'd0);

    // Reset mid-stream
    bus.m_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) push_word(12'(12'h050 + k), 12'h050, 1'b1);
    chk("mid_level5", {28'd0, level_o}, 32'd5);
    rst_a = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", {28'd0, level_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
    chk("mid_rst_afull", {31'd0, bus.Afull_o}, 32'd0);
    @(posedge clk); #1;
    latency("post_rst", 12'h123, 12'hF0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
